vr_transmitter: RTL and testbench

Transmit end of the valid/ready link: accepts words from a local load port into a small FIFO and presents them one at a time to a downstream receiver. `valid` and `data` are held stable until the receiver accepts each word with `ready`. An optional fixed idle gap is inserted after each transfer. The block sits opposite the receiver on the same `clk`, and is the stimulus source for the xmit/recv pair.

---
 rtl/vr_pkg.sv | 11 +
 rtl/vr_fifo.sv | 69 ++++++
 rtl/vr_transmitter.sv | 159 +++++++++++++++
 tb/tb_vr_transmitter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vr_pkg.sv
// Shared types for the valid/ready transmitter and the receiver-side monitors.
package vr_pkg;

  // Transmitter control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } vr_state_t;

endpackage

// File: rtl/vr_fifo.sv
// Small synchronous FIFO: DEPTH x DATA_WIDTH, registered count drives full/empty.
module vr_fifo
  import vr_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push_i,
  input  logic [DATA_WIDTH-1:0]       push_data_i,
  input  logic                        pop_i,
  output logic [DATA_WIDTH-1:0]       head_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [$clog2(DEPTH):0]      count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic                  do_push_s;
  logic                  do_pop_s;

  // Requests are qualified here so a stray push when full or pop when empty is harmless.
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;

  assign full_o  = (count_q == COUNT_FULL);
  assign empty_o = (count_q == {CW{1'b0}});
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointers wrap naturally at DEPTH; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + COUNT_ONE;
        2'b01:   count_q <= count_q - COUNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/vr_transmitter.sv
// Transmit end of a valid/ready link: FIFO-buffered words presented one at a
// time with valid/data held until ready, optional idle gap after each transfer.
module vr_transmitter
  import vr_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 4,
  parameter int GAP_CYCLES  = 0,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_valid,
  input  logic [DATA_WIDTH-1:0]  load_data,
  output logic                   load_ready,
  output logic                   valid,
  input  logic                   ready,
  output logic [DATA_WIDTH-1:0]  data,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] sent_count
);

  localparam bit HAS_GAP = (GAP_CYCLES > 0);
  localparam int GW      = HAS_GAP ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GW-1:0]          GAP_LOAD = GW'(GAP_CYCLES);
  localparam logic [GW-1:0]          GAP_ONE  = GW'(1);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);

  vr_state_t               state_q, state_d;
  logic                    valid_q, valid_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [GW-1:0]           gap_q, gap_d;
  logic [COUNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic                    hs_s;
  logic                    pop_s;
  logic                    fifo_full_s;
  logic                    fifo_empty_s;
  logic [DATA_WIDTH-1:0]   fifo_head_s;
  logic [$clog2(DEPTH):0]  fifo_count_s;

  vr_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (load_valid),
    .push_data_i (load_data),
    .pop_i       (pop_s),
    .head_o      (fifo_head_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s),
    .count_o     (fifo_count_s)
  );

  // valid comes straight from a register, so it never depends on ready.
  assign hs_s       = valid_q && ready;
  assign load_ready = !fifo_full_s;
  assign valid      = valid_q;
  assign data       = data_q;
  assign sent_count = cnt_q;
  assign busy       = (fifo_count_s != '0) || (state_q != IDLE);

  // State and output registers; reset drops any word in flight without counting it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      data_q  <= {DATA_WIDTH{1'b0}};
      gap_q   <= {GW{1'b0}};
      cnt_q   <= {COUNT_WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty_s) state_d = SEND;
        else               state_d = IDLE;
      end
      SEND: begin
        if (hs_s) begin
          if (HAS_GAP)            state_d = GAP;
          else if (!fifo_empty_s) state_d = SEND;
          else                    state_d = IDLE;
        end else begin
          state_d = SEND;
        end
      end
      GAP: begin
        if (gap_q == GAP_ONE) begin
          if (!fifo_empty_s) state_d = SEND;
          else               state_d = IDLE;
        end else begin
          state_d = GAP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output-register, pop, gap-counter and sent-counter updates for each state.
  always_comb begin
    pop_s   = 1'b0;
    valid_d = valid_q;
    data_d  = data_q;
    gap_d   = gap_q;
    if (hs_s) cnt_d = cnt_q + CNT_ONE;
    else      cnt_d = cnt_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          data_d  = fifo_head_s;
          valid_d = 1'b1;
        end else begin
          valid_d = 1'b0;
        end
      end
      SEND: begin
        if (hs_s) begin
          if (HAS_GAP) begin
            valid_d = 1'b0;
            gap_d   = GAP_LOAD;
          end else if (!fifo_empty_s) begin
            pop_s   = 1'b1;
            data_d  = fifo_head_s;
            valid_d = 1'b1;
          end else begin
            valid_d = 1'b0;
          end
        end else begin
          valid_d = 1'b1;
        end
      end
      GAP: begin
        gap_d = gap_q - GAP_ONE;
        if ((gap_q == GAP_ONE) && !fifo_empty_s) begin
          pop_s   = 1'b1;
          data_d  = fifo_head_s;
          valid_d = 1'b1;
        end else begin
          valid_d = 1'b0;
        end
      end
      default: valid_d = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_vr_transmitter.sv
// Self-checking bench for vr_transmitter: directed scenarios plus randomized
// traffic against a queue-based reference model. Two instances share stimulus:
// u_a (no gap, 4-bit counter) and u_g (GAP_CYCLES=2, 16-bit counter).
module tb_vr_transmitter;

  logic        clk = 1'b0;
  logic        rst;
  logic        lv;
  logic [7:0]  ld;
  logic        rdy;

  logic        lr_a, v_a, busy_a;
  logic [7:0]  d_a;
  logic [3:0]  cnt_a;
  logic        lr_g, v_g, busy_g;
  logic [7:0]  d_g;
  logic [15:0] cnt_g;

  int checks = 0;
  int errors = 0;

  // Reference model state (post-edge view of the transmitter).
  logic [7:0] m_q [$];
  bit         m_valid;
  logic [7:0] m_data;
  int         m_gap;
  int         m_cnt;

  always #5 clk = ~clk;

  vr_transmitter #(.DATA_WIDTH(8), .DEPTH(4), .GAP_CYCLES(0), .COUNT_WIDTH(4)) u_a (
    .clk(clk), .rst(rst), .load_valid(lv), .load_data(ld), .load_ready(lr_a),
    .valid(v_a), .ready(rdy), .data(d_a), .busy(busy_a), .sent_count(cnt_a)
  );

  vr_transmitter #(.DATA_WIDTH(8), .DEPTH(4), .GAP_CYCLES(2), .COUNT_WIDTH(16)) u_g (
    .clk(clk), .rst(rst), .load_valid(lv), .load_data(ld), .load_ready(lr_g),
    .valid(v_g), .ready(rdy), .data(d_g), .busy(busy_g), .sent_count(cnt_g)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; lv = 1'b0; ld = 8'h00; rdy = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (v_a !== 1'b0)    begin errors++; $display("FAIL reset_valid got %0b exp 0", v_a); end
    checks++; if (d_a !== 8'h00)   begin errors++; $display("FAIL reset_data got %02h exp 00", d_a); end
    checks++; if (lr_a !== 1'b1)   begin errors++; $display("FAIL reset_load_ready got %0b exp 1", lr_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy_a); end
    checks++; if (cnt_a !== 4'd0)  begin errors++; $display("FAIL reset_count got %0d exp 0", cnt_a); end
    checks++; if (v_g !== 1'b0)    begin errors++; $display("FAIL reset_valid_gap got %0b exp 0", v_g); end
  endtask

  task automatic test_single_word();
    do_reset();
    rdy = 1'b1; lv = 1'b1; ld = 8'hA5;
    tick();
    lv = 1'b0;
    checks++; if (v_a !== 1'b0)    begin errors++; $display("FAIL single_early_valid got %0b exp 0", v_a); end
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL single_busy got %0b exp 1", busy_a); end
    tick();
    checks++; if (v_a !== 1'b1)    begin errors++; $display("FAIL single_valid got %0b exp 1", v_a); end
    checks++; if (d_a !== 8'hA5)   begin errors++; $display("FAIL single_data got %02h exp a5", d_a); end
    tick();
    checks++; if (v_a !== 1'b0)    begin errors++; $display("FAIL single_valid_drop got %0b exp 0", v_a); end
    checks++; if (cnt_a !== 4'd1)  begin errors++; $display("FAIL single_count got %0d exp 1", cnt_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL single_idle_busy got %0b exp 0", busy_a); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      lv = (i < 4);
      ld = 8'(i + 1);
      tick();
      if (i >= 1 && i <= 4) begin
        checks++;
        if (v_a !== 1'b1 || d_a !== 8'(i)) begin
          errors++; $display("FAIL b2b_word%0d got v=%0b d=%02h exp v=1 d=%02h", i, v_a, d_a, 8'(i));
        end
      end
    end
    lv = 1'b0;
    checks++; if (v_a !== 1'b0)   begin errors++; $display("FAIL b2b_end_valid got %0b exp 0", v_a); end
    checks++; if (cnt_a !== 4'd4) begin errors++; $display("FAIL b2b_count got %0d exp 4", cnt_a); end
  endtask

  task automatic test_stall_full();
    logic [7:0] got [$];
    do_reset();
    rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      lv = 1'b1;
      ld = 8'h10 + 8'(i);
      if (i == 5) begin
        checks++; if (lr_a !== 1'b0) begin errors++; $display("FAIL stall_full_ready got %0b exp 0", lr_a); end
      end
      tick();
      if (i >= 1) begin
        checks++;
        if (v_a !== 1'b1 || d_a !== 8'h10) begin
          errors++; $display("FAIL stall_hold%0d got v=%0b d=%02h exp v=1 d=10", i, v_a, d_a);
        end
      end
    end
    lv = 1'b0;
    checks++; if (lr_a !== 1'b0) begin errors++; $display("FAIL stall_still_full got %0b exp 0", lr_a); end
    rdy = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (v_a) got.push_back(d_a);
      tick();
    end
    checks++;
    if (got.size() != 5) begin errors++; $display("FAIL stall_drain_size got %0d exp 5", got.size()); end
    for (int k = 0; k < got.size() && k < 5; k++) begin
      checks++;
      if (got[k] !== 8'h10 + 8'(k)) begin
        errors++; $display("FAIL stall_drain%0d got %02h exp %02h", k, got[k], 8'h10 + 8'(k));
      end
    end
    checks++; if (cnt_a !== 4'd5) begin errors++; $display("FAIL stall_count got %0d exp 5", cnt_a); end
  endtask

  task automatic test_gap();
    logic [7:0] w [3];
    bit         pat [7];
    int         k;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      w[i] = 8'($urandom);
      lv = 1'b1; ld = w[i];
      tick();
    end
    lv = 1'b0;
    rdy = 1'b1;
    k = 0;
    for (int c = 0; c < 7; c++) begin
      checks++;
      if (v_g !== pat[c]) begin errors++; $display("FAIL gap_pattern%0d got %0b exp %0b", c, v_g, pat[c]); end
      if (pat[c] && k < 3) begin
        checks++;
        if (d_g !== w[k]) begin errors++; $display("FAIL gap_data%0d got %02h exp %02h", k, d_g, w[k]); end
        k++;
      end
      tick();
    end
    checks++; if (cnt_g !== 16'd3) begin errors++; $display("FAIL gap_count got %0d exp 3", cnt_g); end
  endtask

  task automatic test_reset_mid_send();
    bit seen;
    do_reset();
    rdy = 1'b0; lv = 1'b1; ld = 8'h3C;
    tick();
    lv = 1'b0;
    tick();
    checks++;
    if (v_a !== 1'b1 || d_a !== 8'h3C) begin errors++; $display("FAIL midrst_pre got v=%0b d=%02h exp v=1 d=3c", v_a, d_a); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (v_a !== 1'b0)   begin errors++; $display("FAIL midrst_valid got %0b exp 0", v_a); end
    checks++; if (d_a !== 8'h00)  begin errors++; $display("FAIL midrst_data got %02h exp 00", d_a); end
    checks++; if (cnt_a !== 4'd0) begin errors++; $display("FAIL midrst_count got %0d exp 0", cnt_a); end
    checks++; if (lr_a !== 1'b1)  begin errors++; $display("FAIL midrst_load_ready got %0b exp 1", lr_a); end
    rdy = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (v_a) seen = 1'b1;
      tick();
    end
    checks++; if (seen)           begin errors++; $display("FAIL midrst_dropped got valid=1 exp never"); end
    checks++; if (cnt_a !== 4'd0) begin errors++; $display("FAIL midrst_no_count got %0d exp 0", cnt_a); end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    rdy = 1'b1;
    for (int i = 0; i < 17; i++) begin
      lv = 1'b1; ld = 8'(i);
      checks++;
      if (lr_a !== 1'b1) begin errors++; $display("FAIL wrap_accept%0d got %0b exp 1", i, lr_a); end
      tick();
    end
    lv = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    checks++; if (cnt_a !== 4'd1) begin errors++; $display("FAIL wrap_count got %0d exp 1", cnt_a); end
  endtask

  // Randomized traffic; the model tracks the queued words, the word on offer
  // and the remaining idle-gap cycles, and advances once per clock edge.
  task automatic test_random(input bit use_gap, input int cycles);
    int         gapc;
    int         mask;
    bit         push_ok;
    logic       ov, olr, obusy;
    logic [7:0] od;
    int         ocnt;
    bit         mbusy;
    gapc = use_gap ? 2 : 0;
    mask = use_gap ? 32'h0000_FFFF : 32'h0000_000F;
    do_reset();
    m_q.delete(); m_valid = 1'b0; m_data = 8'h00; m_gap = 0; m_cnt = 0;
    for (int c = 0; c < cycles; c++) begin
      lv  = ($urandom_range(0, 3) != 0);
      ld  = 8'($urandom);
      rdy = (c % 100 < 50) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
      ov    = use_gap ? v_g    : v_a;
      od    = use_gap ? d_g    : d_a;
      olr   = use_gap ? lr_g   : lr_a;
      obusy = use_gap ? busy_g : busy_a;
      ocnt  = use_gap ? int'(cnt_g) : int'(cnt_a);
      mbusy = (m_q.size() > 0) || m_valid || (m_gap > 0);
      checks++; if (ov !== m_valid) begin errors++; $display("FAIL rnd%0d_valid c=%0d got %0b exp %0b", use_gap, c, ov, m_valid); end
      checks++; if (od !== m_data)  begin errors++; $display("FAIL rnd%0d_data c=%0d got %02h exp %02h", use_gap, c, od, m_data); end
      checks++; if (olr !== (m_q.size() < 4)) begin errors++; $display("FAIL rnd%0d_load_ready c=%0d got %0b exp %0b", use_gap, c, olr, m_q.size() < 4); end
      checks++; if (obusy !== mbusy) begin errors++; $display("FAIL rnd%0d_busy c=%0d got %0b exp %0b", use_gap, c, obusy, mbusy); end
      checks++; if (ocnt != (m_cnt & mask)) begin errors++; $display("FAIL rnd%0d_count c=%0d got %0d exp %0d", use_gap, c, ocnt, m_cnt & mask); end
      push_ok = lv && (m_q.size() < 4);
      if (!m_valid && m_gap == 0) begin
        if (m_q.size() > 0) begin m_data = m_q.pop_front(); m_valid = 1'b1; end
      end else if (m_valid) begin
        if (rdy) begin
          m_cnt++;
          if (gapc > 0) begin m_valid = 1'b0; m_gap = gapc; end
          else if (m_q.size() > 0) m_data = m_q.pop_front();
          else m_valid = 1'b0;
        end
      end else begin
        if (m_gap == 1) begin
          m_gap = 0;
          if (m_q.size() > 0) begin m_data = m_q.pop_front(); m_valid = 1'b1; end
        end else begin
          m_gap--;
        end
      end
      if (push_ok) m_q.push_back(ld);
      tick();
    end
    lv = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; lv = 1'b0; ld = 8'h00; rdy = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_stall_full();
    test_gap();
    test_reset_mid_send();
    test_counter_wrap();
    test_random(1'b0, 400);
    test_random(1'b1, 400);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
